// File: rtl/audio_frame_buffer.sv
// Paces PmodAD1 conversions, captures the selected channel as two's complement
// into ping-pong frame banks, and streams completed frames over valid/ready.
module audio_frame_buffer #(
  parameter int CLK_DIV     = 2268,
  parameter int CAPTURE_DLY = 130,
  parameter int N_LOG2      = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic              adc_start,
  input  logic [11:0]       adc_dout0,
  input  logic [11:0]       adc_dout1,
  input  logic              ch_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       out_data,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [1:0]        dbg_rd_state
);

  localparam int TW    = $clog2(CLK_DIV);
  localparam int DEPTH = 1 << N_LOG2;

  // Stream handshake: a beat transfers in any cycle with out_valid && out_ready;
  // while out_valid && !out_ready, out_data/out_index/out_last are held stable.
  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_LOAD   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  rd_state_t         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [N_LOG2-1:0] wr_idx_q, rd_idx_q, rd_idx_d, rd_addr;
  logic              wr_bank_q, rd_bank_q, overrun_q;
  logic              capture, frame_done, hs, last_hs, swap, rd_en;
  logic [11:0]       sample, wdata, rd0_q, rd1_q;

  logic [11:0] bank0 [DEPTH];
  logic [11:0] bank1 [DEPTH];

  always_comb begin
    timer_d    = (timer_q == TW'(CLK_DIV - 1)) ? '0 : timer_q + TW'(1);
    capture    = (timer_q == TW'(CAPTURE_DLY));
    frame_done = capture && (wr_idx_q == '1);
    hs         = (state_q == RD_STREAM) && out_ready;
    last_hs    = hs && (rd_idx_q == '1);
    // A frame hands over only if the reader is free by the end of this cycle.
    swap       = frame_done && ((state_q == RD_IDLE) || last_hs);
    sample     = ch_sel ? adc_dout1 : adc_dout0;
    wdata      = {~sample[11], sample[10:0]};
    rd_en      = (state_q == RD_LOAD) || hs;
    rd_idx_d   = hs ? rd_idx_q + N_LOG2'(1) : rd_idx_q;
    rd_addr    = hs ? rd_idx_d : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:   if (swap) state_d = RD_LOAD;
      RD_LOAD:   state_d = RD_STREAM;
      RD_STREAM: if (last_hs) state_d = swap ? RD_LOAD : RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RD_IDLE;
      timer_q   <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rd_idx_q <= rd_idx_d;
      if (capture) wr_idx_q <= wr_idx_q + N_LOG2'(1);
      if (swap) begin
        wr_bank_q <= ~wr_bank_q;
        rd_bank_q <= wr_bank_q;
      end
      if (frame_done && !swap) overrun_q <= 1'b1;
      else if (clr_overrun)    overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !wr_bank_q) bank0[wr_idx_q] <= wdata;
    if (rd_en && !rd_bank_q)   rd0_q <= bank0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (capture && wr_bank_q) bank1[wr_idx_q] <= wdata;
    if (rd_en && rd_bank_q)   rd1_q <= bank1[rd_addr];
  end

  // Start pulse is gated by reset so it reads 0 while rst is held low.
  assign adc_start    = rst && (timer_q == '0);
  assign out_valid    = (state_q == RD_STREAM);
  assign out_data     = out_valid ? (rd_bank_q ? rd1_q : rd0_q) : 12'h000;
  assign out_index    = rd_idx_q;
  assign out_last     = out_valid && (rd_idx_q == '1);
  assign overrun      = overrun_q;
  assign dbg_rd_state = state_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer with 8-sample frames, a delayed-ramp
// ADC model and a beat scoreboard.
module tb_audio_frame_buffer;

  localparam int CLK_DIV     = 140;
  localparam int CAPTURE_DLY = 130;
  localparam int N_LOG2      = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        adc_start;
  logic [11:0] adc_dout0 = 12'h000;
  logic [11:0] adc_dout1 = 12'hFFF;
  logic        ch_sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic [1:0]  dbg_rd_state;

  always #5 clk = ~clk;

  audio_frame_buffer #(
    .CLK_DIV(CLK_DIV), .CAPTURE_DLY(CAPTURE_DLY), .N_LOG2(N_LOG2)
  ) dut (
    .clk(clk), .rst(rst), .adc_start(adc_start),
    .adc_dout0(adc_dout0), .adc_dout1(adc_dout1), .ch_sel(ch_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .overrun(overrun),
    .clr_overrun(clr_overrun), .dbg_rd_state(dbg_rd_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  int cd    = 0;
  int ramp  = 0;
  logic rand_ready = 1'b0;
  logic ramp_mode  = 1'b1;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          got_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int rel();
    return cyc - c0;
  endfunction

  function automatic logic [11:0] conv(input int v);
    return 12'(v - 2048);
  endfunction

  // ADC model: each start yields the next ramp value 128 cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      cd   = 0;
      ramp = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          adc_dout0 = ramp_mode ? 12'(ramp) : 12'h800;
          ramp = ramp + 1;
        end
      end
      if (adc_start) cd = 128;
    end
  end

  // Beat monitor plus hold-during-stall check.
  logic        stall_v = 1'b0;
  logic [11:0] pd = 12'h000;
  logic [2:0]  pi = 3'd0;
  always @(negedge clk) begin
    if (!rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data",  32'(out_data),  32'(pd));
        chk("hold_index", 32'(out_index), 32'(pi));
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_index, out_data});
        got_cyc_q.push_back(cyc - c0);
      end
      stall_v = out_valid && !out_ready;
      pd = out_data;
      pi = out_index;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rel(input int t);
    while (rel() < t) step();
  endtask

  task automatic push_exp(input int idx, input logic [11:0] data);
    exp_q.push_back({(idx == 7), 3'(idx), data});
  endtask

  task automatic push_ramp(input int base);
    for (int i = 0; i < 8; i++) push_exp(i, conv(base + i));
  endtask

  task automatic check_frame(input int n, input int budget, input int first_cyc);
    int waited = 0;
    logic [15:0] e, g;
    int gc;
    while (got_q.size() < n && waited < budget) begin
      step();
      waited++;
    end
    if (got_q.size() < n) chk("beat_timeout", 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      e  = exp_q.pop_front();
      g  = got_q.pop_front();
      gc = got_cyc_q.pop_front();
      chk($sformatf("beat%0d", i), 32'(g), 32'(e));
      if (first_cyc >= 0) chk($sformatf("beat%0d_cyc", i), 32'(gc), 32'(first_cyc + i));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start", 32'(adc_start), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    c0  = cyc;
    #1;
    chk("start_first", 32'(adc_start), 32'd1);
    step();
    chk("start_once", 32'(adc_start), 32'd0);
    wait_rel(CLK_DIV - 1);
    chk("start_pre", 32'(adc_start), 32'd0);
    step();
    chk("start_period", 32'(adc_start), 32'd1);
  endtask

  task automatic first_frame();
    out_ready = 1'b1;
    push_ramp(0);
    while (!out_valid && rel() < 1300) step();
    chk("first_valid_cyc", 32'(rel()), 32'd1112);
    check_frame(8, 50, 1112);
  endtask

  initial begin
    // Reset, pacing and first frame latency
    do_reset();
    first_frame();

    // Random backpressure on frame 1
    rand_ready = 1'b1;
    push_ramp(8);
    check_frame(8, 1300, -1);
    rand_ready = 1'b0;
    out_ready  = 1'b0;

    // Overrun: frame 2 held, frames 3 and 4 dropped
    push_ramp(16);
    wait_rel(3352);
    chk("ovr_held_valid", 32'(out_valid), 32'd1);
    chk("ovr_held_index", 32'(out_index), 32'd0);
    wait_rel(4470);
    chk("ovr_before", 32'(overrun), 32'd0);
    step();
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_rel(5600);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    check_frame(8, 40, 5600);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    out_ready = 1'b0;

    // Final handshake of frame 5 coincides with completion of frame 6
    push_ramp(40);
    push_ramp(48);
    wait_rel(6712);
    chk("bnd_valid", 32'(out_valid), 32'd1);
    wait_rel(7823);
    out_ready = 1'b1;
    wait_rel(7830);
    chk("bnd_last", 32'(out_last), 32'd1);
    step();
    chk("bnd_no_ovr", 32'(overrun), 32'd0);
    chk("bnd_load", 32'(dbg_rd_state), 32'd1);
    chk("bnd_gap", 32'(out_valid), 32'd0);
    step();
    chk("bnd_valid2", 32'(out_valid), 32'd1);
    chk("bnd_index0", 32'(out_index), 32'd0);
    check_frame(16, 30, -1);

    // Channel select alternating per capture
    ramp_mode = 1'b0;
    for (int j = 0; j < 8; j++) push_exp(j, (j % 2 == 1) ? 12'h7FF : 12'h000);
    for (int j = 0; j < 8; j++) begin
      wait_rel((56 + j) * CLK_DIV);
      ch_sel = 1'(j % 2);
    end
    check_frame(8, 200, 8952);
    ch_sel    = 1'b0;
    ramp_mode = 1'b1;

    // Reset while streaming index 4 of frame 8
    for (int i = 0; i < 4; i++) push_exp(i, conv(64 + i));
    wait_rel(10076);
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_index", 32'(out_index), 32'd4);
    rst = 1'b0;
    #1;
    chk("async_start", 32'(adc_start), 32'd0);
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_data",  32'(out_data),  32'd0);
    chk("async_index", 32'(out_index), 32'd0);
    chk("async_last",  32'(out_last),  32'd0);
    chk("async_ovr",   32'(overrun),   32'd0);
    check_frame(4, 0, 10072);
    chk("mid_no_extra", 32'(got_q.size()), 32'd0);
    out_ready = 1'b0;
    do_reset();
    first_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_frame_buffer.md
Name: audio_frame_buffer

Overview:
Downstream consumer of the PmodAD1 ADC interface in the audio FFT chain. Paces conversions by issuing the one-cycle start pulse at the audio sample rate and captures the selected 12-bit channel. Converts each sample to two's complement and collects samples into ping-pong frame banks. Streams each completed frame to the FFT stage over a valid/ready handshake.

Parameters:
CLK_DIV, 2268, clk cycles per sample period (100 MHz / 2268 ≈ 44.09 kHz); legal range is at least CAPTURE_DLY+2.
CAPTURE_DLY, 130, timer value at which the ADC output words are sampled. The ADC result is stable from 129 cycles after start.
N_LOG2, 10, log2 of frame length (1024 samples).

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
adc_start  out  1  one-cycle conversion trigger to ADC interface
adc_dout0  in  12  ADC channel 0 result, unsigned offset-binary
adc_dout1  in  12  ADC channel 1 result, unsigned offset-binary
ch_sel  in  1  0 = channel 0, 1 = channel 1; sampled at capture
out_valid  out  1  stream data valid
out_ready  in  1  FFT stage ready
out_data  out  12  signed sample
out_index  out  N_LOG2  sample position within frame
out_last  out  1  high with final sample of frame (index 2^N_LOG2-1)
overrun  out  1  sticky: a completed frame was dropped
clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst low, async): timer=0, write index=0, write bank=0, reader IDLE, both banks empty. All outputs are 0: adc_start, out_valid, out_data, out_index, out_last, overrun.
- Sample timer: counts 0..CLK_DIV-1 and wraps to 0.
  - adc_start=1 exactly in cycles where timer==0, including the first cycle after rst release.
  - Exactly one pulse per period.
- Capture: in the cycle timer==CAPTURE_DLY, take adc_dout0 or adc_dout1 per ch_sel.
  - Conversion is MSB inversion (x-2048), e.g. 0x000->-2048, 0x800->0, 0xFFF->+2047.
  - Write the result to the write bank at the write index, then increment the index.
- Frame complete: the write of index 2^N_LOG2-1 wraps the index to 0.
  - If the reader is IDLE, or is completing its final handshake in the same cycle, swap banks: the full bank goes to the reader and writing continues in the other bank. No sample is lost.
  - Otherwise, drop the just-filled write bank, overwrite it with the next frame, and set overrun=1 in the following cycle.
- overrun: sticky until clr_overrun=1. If set and clear coincide, set wins.
- Reader FSM:
  - IDLE: out_valid=0. On swap, go to LOAD.
  - LOAD: one cycle of RAM read latency for index 0. Go to STREAM.
  - STREAM: out_valid=1. out_data, out_index and out_last hold stable while out_valid && !out_ready.
    - On out_valid && out_ready, advance to the next index with no bubble (prefetch). Throughput is 1 sample/cycle.
    - After the handshake with out_last=1, go to IDLE, or straight to LOAD if a swap occurs that same cycle.
- Latency: first out_valid rises 2 cycles after the capture cycle that completed the frame.
- out_valid must not drop without a handshake. After a frame, out_index restarts at 0.
- Storage: two banks of 2^N_LOG2 x 12, inferred block RAM, one write port and one read port per bank.

Test Plan:
1. N_LOG2=3, CLK_DIV=140, ADC model returns a 128-cycle-late ramp 0x000,0x001,..; out_ready=1 -> adc_start every 140 cycles. First frame streams 8 consecutive beats -2048..-2041 with out_index 0..7, out_last only on index 7, and first out_valid 2 cycles after the 8th capture.
2. Backpressure: out_ready toggles 1,0,0,1,... randomly -> out_data/out_index stable during stalls. All 8 samples are delivered in order with no duplicates.
3. Overrun: out_ready=0 for 3 frame periods -> overrun=1 one cycle after the 2nd frame completes. The first frame is still delivered intact once ready=1. clr_overrun=1 clears the flag.
4. Boundary: release out_ready so the final handshake of frame k lands exactly on the completion cycle of frame k+1 -> no overrun, and LOAD follows immediately.
5. ch_sel: adc_dout0=0x800, adc_dout1=0xFFF, toggle ch_sel between captures -> alternating 0 and +2047.
6. Reset mid-stream: assert rst during STREAM at index 4 -> all outputs go 0 immediately (async). After release, adc_start fires in the first cycle and out_index restarts at 0 on the next frame.
